// File: rtl/sweep_timer_pkg.sv
// Shared types and helpers for the multi-axis sweep-duration timer.
// Channel state encoding, the default counter width and width helpers.
package sweep_timer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      READY  = 2'd2,
      REPLAY = 2'd3
   } state_t;

   localparam int CNT_W_DEF = 22;

   // All-ones value of a w-bit counter; w is expected to stay below 64.
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // Prescaler counter width; a single bit is kept even when PRESCALE is 1.
   function automatic int presc_w(input int p);
      return (p <= 1) ? 1 : $clog2(p);
   endfunction

endpackage

// File: rtl/sweep_timer_if.sv
// Bus between the tracker FSM (master) and the sweep timer (slave).
// All vectors carry one bit (or one CNT_W field) per axis.
interface sweep_timer_if
   import sweep_timer_pkg::*;
#(
   parameter int NUM_AXES = 2,
   parameter int CNT_W    = CNT_W_DEF
);
   logic [NUM_AXES-1:0]       CLR;
   logic [NUM_AXES-1:0]       REC;
   logic [NUM_AXES-1:0]       PLAY_START;
   logic [NUM_AXES-1:0]       HALF;
   logic [NUM_AXES-1:0]       PLAY_ACTIVE;
   logic [NUM_AXES-1:0]       PLAY_DONE;
   logic [NUM_AXES-1:0]       LEN_VALID;
   logic [NUM_AXES-1:0]       OVF;
   logic [NUM_AXES*CNT_W-1:0] SWEEP_LEN;

   modport master (
      output CLR, REC, PLAY_START, HALF,
      input  PLAY_ACTIVE, PLAY_DONE, LEN_VALID, OVF, SWEEP_LEN
   );

   modport slave (
      input  CLR, REC, PLAY_START, HALF,
      output PLAY_ACTIVE, PLAY_DONE, LEN_VALID, OVF, SWEEP_LEN
   );
endinterface

// File: rtl/sweep_channel.sv
// One axis: measures a sweep in prescaler ticks, then replays the stored
// length (or half of it) as a PLAY_ACTIVE window closed by a done pulse.
module sweep_channel
   import sweep_timer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             tick,
   input  logic             clr,
   input  logic             rec,
   input  logic             play_start,
   input  logic             half,
   output logic             play_active,
   output logic             play_done,
   output logic             len_valid,
   output logic             ovf,
   output logic [CNT_W-1:0] len
);

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(sat_max(CNT_W));
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, len_n, load;
   logic             act_n, done_n, vld_n, ovf_n;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         len         <= '0;
         cnt         <= '0;
         play_active <= 1'b0;
         play_done   <= 1'b0;
         len_valid   <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         state       <= state_n;
         len         <= len_n;
         cnt         <= cnt_n;
         play_active <= act_n;
         play_done   <= done_n;
         len_valid   <= vld_n;
         ovf         <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      len_n   = len;
      cnt_n   = cnt;
      act_n   = play_active;
      done_n  = 1'b0;
      vld_n   = len_valid;
      ovf_n   = ovf;
      load    = half ? (len >> 1) : len;

      if (clr) begin
         state_n = IDLE;
         len_n   = '0;
         cnt_n   = '0;
         act_n   = 1'b0;
         vld_n   = 1'b0;
         ovf_n   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rec) begin
                  state_n = RECORD;
                  len_n   = CNT_W'(tick);
               end
            end
            RECORD: begin
               // The falling edge of REC closes the measurement without counting.
               if (!rec) begin
                  state_n = READY;
                  vld_n   = 1'b1;
               end else if (tick) begin
                  if (len == LEN_MAX) ovf_n = 1'b1;
                  else                len_n = len + ONE;
               end
            end
            READY: begin
               if (rec) begin
                  state_n = RECORD;
                  len_n   = CNT_W'(tick);
                  vld_n   = 1'b0;
               end else if (play_start) begin
                  // An empty replay still answers with a done pulse.
                  if (load != '0) begin
                     state_n = REPLAY;
                     cnt_n   = load;
                     act_n   = 1'b1;
                  end else begin
                     done_n  = 1'b1;
                  end
               end
            end
            REPLAY: begin
               if (tick) begin
                  if (cnt == ONE) begin
                     state_n = READY;
                     cnt_n   = '0;
                     act_n   = 1'b0;
                     done_n  = 1'b1;
                  end else begin
                     cnt_n   = cnt - ONE;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sweep_timer.sv
// Sweep-duration timer: a shared tick prescaler feeding NUM_AXES
// independent record/replay channels.
module sweep_timer
   import sweep_timer_pkg::*;
#(
   parameter int NUM_AXES = 2,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int PRESCALE = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   sweep_timer_if.slave bus
);

   localparam int             PW   = presc_w(PRESCALE);
   localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0]                  presc;
   logic                           tick;
   logic [NUM_AXES-1:0]            act, done, vld, ovf;
   logic [NUM_AXES-1:0][CNT_W-1:0] lens;

   // Free-running; only reset realigns it, channel clears do not.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)             presc <= '0;
      else if (presc == PMAX) presc <= '0;
      else                    presc <= presc + PW'(1);
   end

   assign tick = (presc == PMAX);

   for (genvar i = 0; i < NUM_AXES; i++) begin : g_ch
      sweep_channel #(.CNT_W(CNT_W)) u_ch (
         .CLK         (CLK),
         .RST_N       (RST_N),
         .tick        (tick),
         .clr         (bus.CLR[i]),
         .rec         (bus.REC[i]),
         .play_start  (bus.PLAY_START[i]),
         .half        (bus.HALF[i]),
         .play_active (act[i]),
         .play_done   (done[i]),
         .len_valid   (vld[i]),
         .ovf         (ovf[i]),
         .len         (lens[i])
      );
   end

   assign bus.PLAY_ACTIVE = act;
   assign bus.PLAY_DONE   = done;
   assign bus.LEN_VALID   = vld;
   assign bus.OVF         = ovf;
   assign bus.SWEEP_LEN   = lens;

endmodule

// File: doc/sweep_timer.md
# sweep_timer

Multi-axis sweep-duration timer for the solar tracker. Each channel measures how long its servo takes to sweep end-to-end while recording. On request it replays that duration, or half of it to return to mid-travel, as a PLAY_ACTIVE window that gates the fixed-duty PWM during the max-search phases. It sits between the tracker FSM and the per-axis PWM generators. It replaces the single-axis up/down counter with per-channel stored lengths, a shared prescaler, saturation, an explicit done pulse, and a half-replay mode.

## Interface
Parameters:
- NUM_AXES, 2, number of independent channels (0 = horizontal, 1 = vertical)
- CNT_W, 22, width of stored length and replay counter
- PRESCALE, 1, clock cycles per count tick (≥1); 1 = count every cycle

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- CLR  in  NUM_AXES  synchronous per-channel clear
- REC  in  NUM_AXES  level; high = channel is sweeping and being measured
- PLAY_START  in  NUM_AXES  one-cycle request to start a replay
- HALF  in  NUM_AXES  sampled with PLAY_START; 1 = replay floor(len/2)
- PLAY_ACTIVE  out  NUM_AXES  high while replay window is open (successor of CNT_RU)
- PLAY_DONE  out  NUM_AXES  one-cycle pulse when a replay completes
- LEN_VALID  out  NUM_AXES  stored length is valid
- OVF  out  NUM_AXES  sticky; recording saturated
- SWEEP_LEN  out  NUM_AXES*CNT_W  stored length, channel i at bits [i*CNT_W +: CNT_W]

## Operation
- Shared free-running prescaler produces TICK: one cycle in every PRESCALE. It is cleared only by RST_N. With PRESCALE=1, TICK is constant 1.
- Per-channel states: IDLE, RECORD, READY, REPLAY.
- Per-channel priority: CLR > state logic. CLR in any state → IDLE. CLR zeroes len, the down counter, OVF, LEN_VALID and PLAY_ACTIVE, and suppresses PLAY_DONE.
- IDLE: REC=1 → RECORD. len loads TICK (0 or 1). PLAY_START is ignored.
- RECORD:
  - REC=1 and TICK → len+1, saturating at 2^CNT_W−1.
  - A TICK while len is already at max sets OVF.
  - REC=0 → READY and LEN_VALID=1. That edge does not increment.
- READY:
  - REC=1 → RECORD. len reloads TICK and LEN_VALID drops. OVF is kept.
  - Otherwise PLAY_START → load the down counter with len, or len>>1 if HALF.
    - Load ≠ 0: go to REPLAY.
    - Load = 0: stay in READY and pulse PLAY_DONE next cycle, with no PLAY_ACTIVE.
  - REC and PLAY_START in the same cycle: REC wins.
- REPLAY:
  - PLAY_ACTIVE=1.
  - Each TICK decrements the down counter.
  - The TICK that takes it from 1 to 0 returns the channel to READY, with PLAY_DONE=1 on that same next cycle.
  - REC and PLAY_START are ignored.
  - len is retained, so replays are repeatable.
- Channels are fully independent. Only the prescaler is shared.

## Timing
- Reset values: PLAY_ACTIVE=0, PLAY_DONE=0, LEN_VALID=0, OVF=0, SWEEP_LEN=0, all channels IDLE, prescaler=0.
- All outputs are registered. Each takes its new value in the cycle after the triggering edge.
- PRESCALE=1:
  - REC high for N cycles → len = N (saturated).
  - PLAY_START at cycle t with load L → PLAY_ACTIVE high cycles t+1 … t+L, PLAY_DONE high cycle t+L+1.
- PRESCALE>1: PLAY_ACTIVE length lies in [(L−1)·PRESCALE+1, L·PRESCALE] cycles.
- Reset assertion mid-replay drops PLAY_ACTIVE immediately (asynchronous) with no PLAY_DONE.
- HALF on an odd len truncates (len=7 → 3).

## Structure
- Package sweep_timer_pkg holds:
  - the state enum (IDLE, RECORD, READY, REPLAY, 2-bit)
  - the localparam for saturation max derived from CNT_W
  - the prescaler width function clog2(PRESCALE)
- Sub-module sweep_channel holds one channel's FSM, len register and down counter. Top level sweep_timer holds the prescaler plus a generate loop of NUM_AXES sweep_channel instances.

## Test plan
- Reset/basic, PRESCALE=1, CNT_W=22: REC ch0 high 100 cycles → SWEEP_LEN[0]=100 and LEN_VALID[0]=1. PLAY_START → PLAY_ACTIVE high exactly 100 cycles, then one PLAY_DONE pulse. ch1 stays 0.
- Half mode: len=7, HALF=1 → PLAY_ACTIVE 3 cycles. len=1, HALF=1 → no PLAY_ACTIVE, PLAY_DONE next cycle.
- Saturation, CNT_W=4: REC high 20 cycles → len=15, OVF=1. OVF survives re-record and is cleared only by CLR or RST_N.
- Prescale, PRESCALE=4: REC held 40 cycles aligned to a tick → len=10. Replay PLAY_ACTIVE is 37–40 cycles.
- Abort/priority:
  - CLR mid-replay → PLAY_ACTIVE low next cycle, no PLAY_DONE, LEN_VALID=0.
  - RST_N low mid-replay → all outputs 0 asynchronously.
  - REC with PLAY_START together in READY → RECORD.
- Independence: ch0 replaying while ch1 records. Each channel's counts match its standalone run.
